// File: rtl/imem_uart_loader.sv
// imem_uart_loader: boot-time program loader for the instruction memory.
// It receives an image over UART (8N1, LSB first). The image is a 16-bit little-endian word
// count followed by that many 32-bit little-endian words. Each word is written through the
// imem write port. The core is held in reset until the whole image has been accepted.
// Optional feature macro IMEM_LOADER_CHECKSUM_EN: a trailing byte must equal the 8-bit sum
// of all data bytes before the core is released.
module imem_uart_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  uart_rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_reset_n,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int unsigned   CntW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned   IdxW    = ADDR_WIDTH + 1;
    localparam logic [CntW-1:0] HalfBit = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] FullBit = CntW'(CLKS_PER_BIT - 1);
    localparam logic [16:0]   Depth   = 17'(2 ** ADDR_WIDTH);

    // ------------------------------------------------------------------
    // UART receive front end
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

    rx_state_e           rx_state_q, rx_state_d;
    logic                rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CntW-1:0]     clk_cnt_q, clk_cnt_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          rx_shift_q, rx_shift_d;
    logic                byte_valid_q, byte_valid_d;
    logic                frame_err_q, frame_err_d;

    // Receiver next state: detect start edge, sample bits, check the stop bit.
    always_comb begin
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (rx_state_q)
            R_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = R_START;
                    clk_cnt_d  = '0;
                    bit_cnt_d  = '0;
                end
            end
            R_START: begin
                if (clk_cnt_q == HalfBit) begin
                    clk_cnt_d  = '0;
                    // A line that is high again mid start bit was only a glitch.
                    rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            R_DATA: begin
                if (clk_cnt_q == FullBit) begin
                    clk_cnt_d  = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            R_STOP: begin
                if (clk_cnt_q == FullBit) begin
                    clk_cnt_d    = '0;
                    rx_state_d   = R_IDLE;
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // Receiver state, input synchronizer and edge-detect history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= R_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= uart_rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Image loader
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        L_LEN0,
        L_LEN1,
        L_DATA,
        L_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        L_CSUM,
`endif
        L_DONE,
        L_ERR
    } ld_state_e;

    ld_state_e             ld_state_q, ld_state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [15:0]           len_q, len_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_WIDTH-1:0] imem_wdata_q, imem_wdata_d;
    logic                  cpu_reset_n_q, cpu_reset_n_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    logic [15:0] len_full;
    logic        len_bad;
    logic        last_word;

    assign len_full  = {rx_shift_q, len_lo_q};
    assign len_bad   = (len_full == 16'd0) || (17'(len_full) > Depth);
    // Index is one bit wider than the address so a full-depth image cannot wrap.
    assign last_word = (17'(idx_q) + 17'd1) == 17'(len_q);

    // Loader next state: length header, byte assembly, word write, completion.
    always_comb begin
        ld_state_d    = ld_state_q;
        len_lo_d      = len_lo_q;
        len_d         = len_q;
        idx_d         = idx_q;
        byte_idx_d    = byte_idx_q;
        imem_we_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_wdata_d  = imem_wdata_q;
        cpu_reset_n_d = cpu_reset_n_q;
        load_done_d   = load_done_q;
        load_err_d    = load_err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d         = sum_q;
`endif
        unique case (ld_state_q)
            L_LEN0: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_d = '0;
`endif
                if (byte_valid_q) begin
                    len_lo_d   = rx_shift_q;
                    ld_state_d = L_LEN1;
                end
            end
            L_LEN1: begin
                if (byte_valid_q) begin
                    len_d      = len_full;
                    idx_d      = '0;
                    byte_idx_d = '0;
                    if (len_bad) begin
                        ld_state_d = L_ERR;
                        load_err_d = 1'b1;
                    end else begin
                        ld_state_d = L_DATA;
                    end
                end
            end
            L_DATA: begin
                if (byte_valid_q) begin
                    imem_wdata_d[{byte_idx_q, 3'b000} +: 8] = rx_shift_q;
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d = sum_q + rx_shift_q;
`endif
                    if (byte_idx_q == 2'd3) begin
                        ld_state_d  = L_WRITE;
                        imem_we_d   = 1'b1;
                        imem_addr_d = idx_q[ADDR_WIDTH-1:0];
                    end
                end
            end
            L_WRITE: begin
                idx_d = idx_q + IdxW'(1);
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    ld_state_d = L_CSUM;
`else
                    ld_state_d    = L_DONE;
                    cpu_reset_n_d = 1'b1;
                    load_done_d   = 1'b1;
`endif
                end else begin
                    ld_state_d = L_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            L_CSUM: begin
                if (byte_valid_q) begin
                    if (rx_shift_q == sum_q) begin
                        ld_state_d    = L_DONE;
                        cpu_reset_n_d = 1'b1;
                        load_done_d   = 1'b1;
                    end else begin
                        ld_state_d = L_ERR;
                        load_err_d = 1'b1;
                    end
                end
            end
`endif
            L_DONE: ;
            L_ERR:  ;
            default: ld_state_d = L_ERR;
        endcase

        // A framing error anywhere in an active load kills it.
        if (frame_err_q && (ld_state_q != L_DONE) && (ld_state_q != L_ERR)) begin
            ld_state_d    = L_ERR;
            load_err_d    = 1'b1;
            imem_we_d     = 1'b0;
            cpu_reset_n_d = 1'b0;
            load_done_d   = 1'b0;
        end
    end

    // Loader state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_state_q    <= L_LEN0;
            len_lo_q      <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            byte_idx_q    <= '0;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_wdata_q  <= '0;
            cpu_reset_n_q <= 1'b0;
            load_done_q   <= 1'b0;
            load_err_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q         <= '0;
`endif
        end else begin
            ld_state_q    <= ld_state_d;
            len_lo_q      <= len_lo_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            byte_idx_q    <= byte_idx_d;
            imem_we_q     <= imem_we_d;
            imem_addr_q   <= imem_addr_d;
            imem_wdata_q  <= imem_wdata_d;
            cpu_reset_n_q <= cpu_reset_n_d;
            load_done_q   <= load_done_d;
            load_err_q    <= load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q         <= sum_d;
`endif
        end
    end

    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign cpu_reset_n = cpu_reset_n_q;
    assign load_done   = load_done_q;
    assign load_err    = load_err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader with CLKS_PER_BIT=8 and ADDR_WIDTH=10.
// Honours IMEM_LOADER_CHECKSUM_EN by sending the trailing checksum byte when it is defined.
module tb_imem_uart_loader;

    localparam int unsigned CPB = 8;
    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          uart_rx;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          cpu_reset_n;
    logic          load_done;
    logic          load_err;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int base;
    bit seen;
    logic [AW-1:0] log_addr [0:31];
    logic [DW-1:0] log_data [0:31];

    always #5 clk = ~clk;

    imem_uart_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .uart_rx    (uart_rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset_n(cpu_reset_n),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    // Log every write strike seen on the memory port.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (we_cnt < 32) begin
                log_addr[we_cnt] = imem_addr;
                log_data[we_cnt] = imem_wdata;
            end
            we_cnt = we_cnt + 1;
        end
    end

    // Hard stop if the run never finishes on its own.
    initial begin
        #3ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        assert (got === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_len(input logic [15:0] n);
        send_byte(n[7:0], 1'b1);
        send_byte(n[15:8], 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic wait_we(input int max, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (imem_we === 1'b1) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int max, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (load_done === 1'b1) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Close a load: send the checksum if enabled, then expect completion.
    task automatic finish_load(input string tag, input logic [7:0] csum);
        bit hit;
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(csum, 1'b1);
`else
        if (csum == 8'h00) idle(1);
`endif
        wait_done(400, hit);
        check(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state while reset is held.
        check("rst_we",          32'(imem_we),     32'd0);
        check("rst_addr",        32'(imem_addr),   32'd0);
        check("rst_wdata",       imem_wdata,       32'd0);
        check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        check("rst_done",        32'(load_done),   32'd0);
        check("rst_err",         32'(load_err),    32'd0);
        reset_n = 1'b1;
        idle(4);

        // Single-word image.
        base = we_cnt;
        send_len(16'd1);
        send_word(32'h00A0_0513);
        wait_we(200, seen);
        check("t1_we_seen",      32'(seen),        32'd1);
        check("t1_addr",         32'(imem_addr),   32'd0);
        check("t1_wdata",        imem_wdata,       32'h00A0_0513);
        check("t1_done_at_we",   32'(load_done),   32'd0);
        check("t1_cpu_at_we",    32'(cpu_reset_n), 32'd0);
        @(negedge clk);
        check("t1_we_one_cycle", 32'(imem_we),     32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t1_wait_csum",    32'(load_done),   32'd0);
        finish_load("t1_done_seen", 8'hB8);
`endif
        check("t1_done",         32'(load_done),   32'd1);
        check("t1_cpu_release",  32'(cpu_reset_n), 32'd1);
        check("t1_no_err",       32'(load_err),    32'd0);
        send_word(32'h1234_5678);
        idle(20);
        check("t1_ignored",      32'(we_cnt - base), 32'd1);
        check("t1_done_sticky",  32'(load_done),   32'd1);

        // Three-word image.
        do_reset();
        base = we_cnt;
        send_len(16'd3);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        idle(10);
        check("t2_two_writes",   32'(we_cnt - base), 32'd2);
        check("t2_not_done",     32'(load_done),   32'd0);
        check("t2_cpu_held",     32'(cpu_reset_n), 32'd0);
        send_word(32'hFFDF_F06F);
        finish_load("t2_done_seen", 8'hF3);
        check("t2_three_writes", 32'(we_cnt - base), 32'd3);
        check("t2_addr0",        32'(log_addr[base]),     32'd0);
        check("t2_addr1",        32'(log_addr[base + 1]), 32'd1);
        check("t2_addr2",        32'(log_addr[base + 2]), 32'd2);
        check("t2_data0",        log_data[base],          32'h0000_0013);
        check("t2_data1",        log_data[base + 1],      32'h0010_0093);
        check("t2_data2",        log_data[base + 2],      32'hFFDF_F06F);
        check("t2_addr_hold",    32'(imem_addr),   32'd2);
        check("t2_cpu_release",  32'(cpu_reset_n), 32'd1);

        // Reset from the done state drops the core reset without a clock edge.
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_cpu_reset", 32'(cpu_reset_n), 32'd0);
        check("async_done_clr",  32'(load_done),   32'd0);
        idle(2);
        reset_n = 1'b1;
        idle(2);

        // Illegal lengths: zero and one past the memory depth.
        base = we_cnt;
        send_len(16'd0);
        idle(5);
        check("t3_len0_err",     32'(load_err),    32'd1);
        check("t3_len0_cpu",     32'(cpu_reset_n), 32'd0);
        do_reset();
        send_len(16'd1025);
        idle(5);
        check("t3_len1025_err",  32'(load_err),    32'd1);
        send_word(32'hAAAA_AAAA);
        idle(20);
        check("t3_no_write",     32'(we_cnt - base), 32'd0);
        check("t3_cpu_held",     32'(cpu_reset_n), 32'd0);
        check("t3_not_done",     32'(load_done),   32'd0);

        // Framing error on the second data byte.
        do_reset();
        base = we_cnt;
        send_len(16'd1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h05, 1'b0);
        idle(5);
        check("t4_frame_err",    32'(load_err),    32'd1);
        send_byte(8'hA0, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(20);
        check("t4_no_write",     32'(we_cnt - base), 32'd0);
        check("t4_not_done",     32'(load_done),   32'd0);
        check("t4_cpu_held",     32'(cpu_reset_n), 32'd0);

        // Short low glitch on an idle line must not produce a byte or an error.
        do_reset();
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        idle(40);
        check("t5_glitch_no_err", 32'(load_err),   32'd0);
        send_len(16'd1);
        send_word(32'h00A0_0513);
        wait_we(200, seen);
        check("t5_we_seen",      32'(seen),        32'd1);
        check("t5_wdata",        imem_wdata,       32'h00A0_0513);
        finish_load("t5_done_seen", 8'hB8);
        check("t5_no_err",       32'(load_err),    32'd0);

        // Reset mid-word, then reload.
        do_reset();
        base = we_cnt;
        send_len(16'd1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        idle(5);
        check("t6_no_partial",   32'(we_cnt - base), 32'd0);
        do_reset();
        check("t6_cpu_held",     32'(cpu_reset_n), 32'd0);
        send_len(16'd1);
        send_word(32'hDEAD_BEEF);
        wait_we(200, seen);
        check("t6_we_seen",      32'(seen),        32'd1);
        check("t6_addr",         32'(imem_addr),   32'd0);
        check("t6_wdata",        imem_wdata,       32'hDEAD_BEEF);
        finish_load("t6_done_seen", 8'h38);
        check("t6_cpu_release",  32'(cpu_reset_n), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum is rejected.
        do_reset();
        send_len(16'd1);
        send_word(32'h00A0_0513);
        send_byte(8'hB9, 1'b1);
        idle(10);
        check("t7_csum_err",     32'(load_err),    32'd1);
        check("t7_csum_cpu",     32'(cpu_reset_n), 32'd0);
        check("t7_csum_not_done", 32'(load_done),  32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Boot-time program loader upstream of the single-cycle core's instruction memory.
- Receives a program image over a UART serial line and writes it word-by-word through the instruction memory write port (we/addr/write_data).
- Holds the core in reset while loading and releases it only after a complete, valid image has been written.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum legal value 4.
- ADDR_WIDTH, 10, instruction memory word-address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- uart_rx  in  1  serial input, idle high, 8N1, LSB first, asynchronous to clk.
- imem_we  out  1  one-cycle write strike to instruction memory.
- imem_addr  out  ADDR_WIDTH  word address for the write.
- imem_wdata  out  DATA_WIDTH  assembled instruction word.
- cpu_reset_n  out  1  active-low reset to the core; low until load succeeds.
- load_done  out  1  high (sticky) once image is fully written and accepted.
- load_err  out  1  high (sticky) on framing error or illegal length.

Behaviour:
- One clock domain. reset_n is asynchronous and active-low; all state is cleared on assertion.
- Reset values:
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_reset_n=0, load_done=0, load_err=0.
  - RX synchronizer flops=1.
- Reset asserted mid-load abandons the load. cpu_reset_n drops asynchronously. Words already written stay in memory and are simply overwritten by the next load.
- RX front end:
  - 2-flop synchronizer on uart_rx; all decisions use the synchronized value.
  - RX FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: falling edge (1->0) enters R_START with the bit counter cleared.
  - R_START: at CLKS_PER_BIT/2 (integer division), sample. If 1, glitch: return to R_IDLE with no byte and no error. If 0, go to R_DATA.
  - R_DATA: sample 8 bits every CLKS_PER_BIT, LSB first.
  - R_STOP: sample after CLKS_PER_BIT. If 1, pulse byte_valid for 1 cycle. If 0, pulse frame_err for 1 cycle and discard the byte. Either way return to R_IDLE.
- Loader FSM states: L_LEN0, L_LEN1, L_DATA, L_WRITE, L_CSUM (feature only), L_DONE, L_ERR.
  - L_LEN0 -> L_LEN1 on byte (length low byte). L_LEN1 -> L_DATA on byte (length high byte).
  - Length N is 16-bit little-endian. N==0 or N>2**ADDR_WIDTH -> L_ERR at the cycle after the high byte.
  - L_DATA: shift bytes little-endian into imem_wdata (byte k into bits 8k+7:8k). The 4th byte moves to L_WRITE.
  - L_WRITE: exactly one cycle with imem_we=1, imem_addr=word index, imem_wdata=assembled word.
  - After the write, the index increments. If the written index == N-1, go to L_DONE (or L_CSUM); otherwise go to L_DATA.
  - Latency: imem_we asserts 1 cycle after the byte_valid of the 4th byte of a word.
  - Bytes arriving in L_WRITE cannot occur, since a byte takes at least 10*CLKS_PER_BIT cycles. No buffering is required.
  - L_DONE: cpu_reset_n=1 and load_done=1 from the cycle of entry. Further RX bytes are ignored. Exit only via reset_n.
  - L_ERR: load_err=1, cpu_reset_n stays 0, imem_we stays 0, RX ignored. Exit only via reset_n.
  - frame_err in any loader state other than L_DONE/L_ERR -> L_ERR next cycle.
- imem_addr holds its last value when idle. imem_we is never high outside L_WRITE.
- Index width is ADDR_WIDTH+1 bits, so the comparison for N==2**ADDR_WIDTH does not wrap.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last write, the FSM enters L_CSUM and waits for one trailing byte.
  - That byte must equal the 8-bit modular sum of all data bytes; length bytes are excluded.
  - Match -> L_DONE. Mismatch or frame_err -> L_ERR.
  - The running sum clears in L_LEN0.
- Undefined: no L_CSUM state. The last write goes directly to L_DONE, and no sum logic is present.

Test Plan:
- CLKS_PER_BIT=8; send 01 00, then 13 05 A0 00 -> one imem_we pulse, addr=0, wdata=0x00A00513; 1 cycle later cpu_reset_n=1 and load_done=1.
- N=3 with words 0x00000013, 0x00100093, 0xFFDFF06F -> three we pulses at addr 0,1,2 with those values; load_done only after the third.
- Length 00 00, then separately length 01 04 (N=1025 with ADDR_WIDTH=10) -> load_err=1, no imem_we ever, cpu_reset_n stays 0.
- Stop bit driven 0 on the 2nd data byte -> load_err=1, no write, later bytes ignored; a 3-cycle low glitch on idle uart_rx -> no byte, no error.
- Assert reset_n mid-word (after 2 data bytes) then reload N=1 with 0xDEADBEEF -> cpu_reset_n=0 immediately on reset; the new load writes addr 0 = 0xDEADBEEF.
- With IMEM_LOADER_CHECKSUM_EN, N=1, word 13 05 A0 00: checksum 0xB8 -> load_done=1; checksum 0xB9 -> load_err=1, cpu_reset_n=0.
